// File: rtl/lc3b_mem_sequencer_pkg.sv
// Shared LC-3b types for the data-memory sequencer: word/byte/mask aliases,
// the memory-op and sequencer-state enums, and small op-decode helpers.
package lc3b_mem_sequencer_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [7:0]  lc3b_byte;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    mop_ldw = 3'd0,
    mop_ldb = 3'd1,
    mop_stw = 3'd2,
    mop_stb = 3'd3,
    mop_ldi = 3'd4,
    mop_sti = 3'd5
  } lc3b_memop;

  typedef enum logic [1:0] {
    ms_idle = 2'd0,
    ms_ptr  = 2'd1,
    ms_acc  = 2'd2
  } lc3b_memseq_state;

  function automatic logic memop_is_store(input lc3b_memop op);
    case (op)
      mop_stw, mop_stb, mop_sti: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic memop_is_indirect(input lc3b_memop op);
    case (op)
      mop_ldi, mop_sti: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic lc3b_word sext8(input lc3b_byte b);
    return {{8{b[7]}}, b};
  endfunction

  function automatic lc3b_word word_align(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering for the memory sequencer: store replication and write
// mask generation, plus lane select and sign extension for byte loads.
module lc3b_byte_lane
  import lc3b_mem_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        addr_lsb,
  input  logic [15:0] wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] store_data,
  output logic [1:0]  store_mask,
  output logic [15:0] load_data
);

  // Lane steering; loads produce no write mask at all.
  always_comb begin
    store_data = 16'h0000;
    store_mask = 2'b00;
    load_data  = mem_rdata;
    case (lc3b_memop'(op))
      mop_stb: begin
        store_data = {wdata[7:0], wdata[7:0]};
        if (addr_lsb) begin
          store_mask = 2'b10;
        end else begin
          store_mask = 2'b01;
        end
      end
      mop_stw, mop_sti: begin
        store_data = wdata;
        store_mask = 2'b11;
      end
      mop_ldb: begin
        if (addr_lsb) begin
          load_data = sext8(mem_rdata[15:8]);
        end else begin
          load_data = sext8(mem_rdata[7:0]);
        end
      end
      default: begin
        store_data = 16'h0000;
        store_mask = 2'b00;
        load_data  = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lc3b_mem_sequencer.sv
// LC-3b data-memory sequencer: accepts one request from control, runs the
// (optionally indirect) memory handshake with a watchdog, and pulses done/err.
module lc3b_mem_sequencer
  import lc3b_mem_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int          CW    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic        WD_EN = (MAX_WAIT > 0);
  localparam logic [CW-1:0] LIMIT = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] ZERO  = {CW{1'b0}};

  lc3b_memseq_state state_r, state_nxt;
  lc3b_memop        op_r, op_nxt;
  lc3b_word         addr_r, addr_nxt;
  lc3b_word         wdata_r, wdata_nxt;
  logic [CW-1:0]    wait_cnt_r, wait_cnt_nxt;

  logic          req_ready_r, req_ready_nxt;
  logic          done_r, done_nxt;
  logic          err_r, err_nxt;
  lc3b_word      rdata_r, rdata_nxt;
  lc3b_word      mem_address_r, mem_address_nxt;
  logic          mem_read_r, mem_read_nxt;
  logic          mem_write_r, mem_write_nxt;
  lc3b_mem_wmask mem_wmask_r, mem_wmask_nxt;
  lc3b_word      mem_wdata_r, mem_wdata_nxt;

  lc3b_memop     req_op_s;
  logic [2:0]    lane_op_s;
  logic          lane_lsb_s;
  lc3b_word      lane_wdata_s;
  lc3b_word      lane_store_s;
  lc3b_mem_wmask lane_mask_s;
  lc3b_word      lane_load_s;
  logic          strobe_s;
  logic          timeout_s;

  assign req_op_s  = lc3b_memop'(req_op);
  assign strobe_s  = mem_read_r | mem_write_r;
  // The limit cycle only aborts when no response arrives in it.
  assign timeout_s = WD_EN && strobe_s && !mem_resp && (wait_cnt_r == LIMIT);

  // In IDLE the lane logic looks at the incoming request so direct accesses
  // can raise their strobe and mask on the acceptance edge.
  assign lane_op_s    = (state_r == ms_idle) ? req_op        : op_r;
  assign lane_lsb_s   = (state_r == ms_idle) ? req_addr[0]   : addr_r[0];
  assign lane_wdata_s = (state_r == ms_idle) ? req_wdata     : wdata_r;

  lc3b_byte_lane u_byte_lane (
    .op         (lane_op_s),
    .addr_lsb   (lane_lsb_s),
    .wdata      (lane_wdata_s),
    .mem_rdata  (mem_rdata),
    .store_data (lane_store_s),
    .store_mask (lane_mask_s),
    .load_data  (lane_load_s)
  );

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_nxt       = state_r;
    op_nxt          = op_r;
    addr_nxt        = addr_r;
    wdata_nxt       = wdata_r;
    wait_cnt_nxt    = wait_cnt_r;
    req_ready_nxt   = 1'b0;
    done_nxt        = 1'b0;
    err_nxt         = 1'b0;
    rdata_nxt       = rdata_r;
    mem_address_nxt = mem_address_r;
    mem_read_nxt    = mem_read_r;
    mem_write_nxt   = mem_write_r;
    mem_wmask_nxt   = mem_wmask_r;
    mem_wdata_nxt   = mem_wdata_r;

    case (state_r)
      ms_idle: begin
        if (req_valid && req_ready_r) begin
          op_nxt          = req_op_s;
          addr_nxt        = req_addr;
          wdata_nxt       = req_wdata;
          wait_cnt_nxt    = ZERO;
          mem_address_nxt = word_align(req_addr);
          if (memop_is_indirect(req_op_s)) begin
            state_nxt    = ms_ptr;
            mem_read_nxt = 1'b1;
          end else begin
            state_nxt     = ms_acc;
            mem_read_nxt  = !memop_is_store(req_op_s);
            mem_write_nxt = memop_is_store(req_op_s);
            mem_wmask_nxt = lane_mask_s;
            mem_wdata_nxt = lane_store_s;
          end
        end else begin
          req_ready_nxt = 1'b1;
        end
      end

      ms_ptr: begin
        if (mem_resp) begin
          state_nxt    = ms_acc;
          addr_nxt     = mem_rdata;
          mem_read_nxt = 1'b0;
          wait_cnt_nxt = ZERO;
        end else if (timeout_s) begin
          state_nxt    = ms_idle;
          mem_read_nxt = 1'b0;
          err_nxt      = 1'b1;
          wait_cnt_nxt = ZERO;
        end else if (WD_EN) begin
          wait_cnt_nxt = wait_cnt_r + ONE;
        end else begin
          wait_cnt_nxt = wait_cnt_r;
        end
      end

      ms_acc: begin
        // Strobes low here means we just came from PTR: raise them now.
        if (!strobe_s) begin
          mem_address_nxt = word_align(addr_r);
          mem_read_nxt    = !memop_is_store(op_r);
          mem_write_nxt   = memop_is_store(op_r);
          mem_wmask_nxt   = lane_mask_s;
          mem_wdata_nxt   = lane_store_s;
          wait_cnt_nxt    = ZERO;
        end else if (mem_resp) begin
          if (memop_is_store(op_r)) begin
            rdata_nxt = rdata_r;
          end else begin
            rdata_nxt = lane_load_s;
          end
          state_nxt     = ms_idle;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          mem_wmask_nxt = 2'b00;
          mem_wdata_nxt = 16'h0000;
          done_nxt      = 1'b1;
          wait_cnt_nxt  = ZERO;
        end else if (timeout_s) begin
          state_nxt     = ms_idle;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          mem_wmask_nxt = 2'b00;
          mem_wdata_nxt = 16'h0000;
          err_nxt       = 1'b1;
          wait_cnt_nxt  = ZERO;
        end else if (WD_EN) begin
          wait_cnt_nxt = wait_cnt_r + ONE;
        end else begin
          wait_cnt_nxt = wait_cnt_r;
        end
      end

      default: begin
        state_nxt     = ms_idle;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        mem_wmask_nxt = 2'b00;
        wait_cnt_nxt  = ZERO;
      end
    endcase
  end

  // State and registered-output update; reset drops the strobes at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ms_idle;
      op_r          <= mop_ldw;
      addr_r        <= 16'h0000;
      wdata_r       <= 16'h0000;
      wait_cnt_r    <= ZERO;
      req_ready_r   <= 1'b1;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      rdata_r       <= 16'h0000;
      mem_address_r <= 16'h0000;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_wmask_r   <= 2'b00;
      mem_wdata_r   <= 16'h0000;
    end else begin
      state_r       <= state_nxt;
      op_r          <= op_nxt;
      addr_r        <= addr_nxt;
      wdata_r       <= wdata_nxt;
      wait_cnt_r    <= wait_cnt_nxt;
      req_ready_r   <= req_ready_nxt;
      done_r        <= done_nxt;
      err_r         <= err_nxt;
      rdata_r       <= rdata_nxt;
      mem_address_r <= mem_address_nxt;
      mem_read_r    <= mem_read_nxt;
      mem_write_r   <= mem_write_nxt;
      mem_wmask_r   <= mem_wmask_nxt;
      mem_wdata_r   <= mem_wdata_nxt;
    end
  end

  assign req_ready   = req_ready_r;
  assign done        = done_r;
  assign err         = err_r;
  assign rdata       = rdata_r;
  assign mem_address = mem_address_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_wmask   = mem_wmask_r;
  assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// Bench for lc3b_mem_sequencer: directed vector table, hand-written reset and
// stray-handshake sequences, then random requests against a transaction model.
module tb_lc3b_mem_sequencer;
  import lc3b_mem_sequencer_pkg::*;

  localparam int MW = 4;

  localparam logic [2:0] LDW = 3'd0;
  localparam logic [2:0] LDB = 3'd1;
  localparam logic [2:0] STW = 3'd2;
  localparam logic [2:0] STB = 3'd3;
  localparam logic [2:0] LDI = 3'd4;
  localparam logic [2:0] STI = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_resp = 1'b0;
  logic        req_ready, done, err, mem_read, mem_write;
  logic [15:0] rdata, mem_address, mem_wdata;
  logic [1:0]  mem_wmask;

  lc3b_mem_sequencer #(.MAX_WAIT(MW)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        has_pre0;
    logic [15:0] pre0;
    logic        has_pre1;
    logic [15:0] pre1;
    int          lat0;
    int          lat1;
    logic        exp_done;
    logic [15:0] exp_rdata;
    int          exp_nacc;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    logic [1:0]  exp_mask;
    logic [15:0] exp_wd;
  } vec_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  string cur_tag = "init";

  logic [15:0] mem [logic [15:0]];
  logic [15:0] model_rdata = 16'h0000;

  int          obs_nacc;
  logic [15:0] obs_addr [2];
  logic        obs_w    [2];
  logic [1:0]  obs_mask [2];
  logic [15:0] obs_wd   [2];
  int          obs_len  [2];
  int          obs_gap;
  logic        obs_done, obs_err;
  logic [15:0] obs_rdata;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h expected %0h", cur_tag, name, act, expv);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA55A;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic is_st(input logic [2:0] op);
    return (op == STW) || (op == STB) || (op == STI);
  endfunction

  function automatic logic is_ind(input logic [2:0] op);
    return (op == LDI) || (op == STI);
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                              input logic hp0, input logic [15:0] p0, input logic hp1, input logic [15:0] p1,
                              input int l0, input int l1, input logic ed, input logic [15:0] er,
                              input int na, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [1:0] m, input logic [15:0] ewd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd;
    v.has_pre0 = hp0; v.pre0 = p0; v.has_pre1 = hp1; v.pre1 = p1;
    v.lat0 = l0; v.lat1 = l1; v.exp_done = ed; v.exp_rdata = er;
    v.exp_nacc = na; v.exp_a0 = a0; v.exp_a1 = a1; v.exp_mask = m; v.exp_wd = ewd;
    return v;
  endfunction

  // Transaction-level model: derives expected accesses and results from the op rules.
  task automatic build_rand(output vec_t v);
    logic [15:0] p, fa, w;
    logic [7:0]  b;
    v = mk(3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0,
           0, 0, 1'b0, 16'h0, 1, 16'h0, 16'h0, 2'b00, 16'h0);
    if ($urandom_range(0, 3) == 0) v.addr = 16'($urandom_range(0, 31));
    v.lat0 = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
    v.lat1 = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
    v.exp_a0 = {v.addr[15:1], 1'b0};
    fa = v.exp_a0;
    if (is_ind(v.op) && v.lat0 <= MW) begin
      p = mem_rd(v.exp_a0);
      fa = {p[15:1], 1'b0};
      v.exp_a1 = fa;
      v.exp_nacc = 2;
    end
    v.exp_done = (v.lat0 <= MW) && (!is_ind(v.op) || v.lat1 <= MW);
    v.exp_rdata = model_rdata;
    if (v.exp_done && !is_st(v.op)) begin
      w = mem_rd(fa);
      if (v.op == LDB) begin
        b = v.addr[0] ? w[15:8] : w[7:0];
        v.exp_rdata = {{8{b[7]}}, b};
      end else begin
        v.exp_rdata = w;
      end
    end
    if (v.op == STB) begin
      v.exp_mask = v.addr[0] ? 2'b10 : 2'b01;
      v.exp_wd = {v.wdata[7:0], v.wdata[7:0]};
    end else begin
      v.exp_mask = 2'b11;
      v.exp_wd = v.wdata;
    end
  endtask

  // Issue one request and act as the memory, recording every access seen.
  task automatic run_txn(input vec_t v, input logic hold_junk);
    int lat [2];
    int low;
    int idx;
    logic prev_st, st, fin;
    logic [15:0] t;
    lat[0] = v.lat0; lat[1] = v.lat1;
    obs_nacc = 0; obs_gap = 0; obs_done = 1'b0; obs_err = 1'b0; obs_rdata = 16'h0;
    obs_len[0] = 0; obs_len[1] = 0;
    low = 0; prev_st = 1'b0; fin = 1'b0;
    if (v.has_pre0) mem[{v.addr[15:1], 1'b0}] = v.pre0;
    if (v.has_pre1) mem[{v.pre0[15:1], 1'b0}] = v.pre1;
    for (int k = 0; k < 10 && req_ready !== 1'b1; k++) @(negedge clk);
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = 16'($urandom);
      if (c == 0) begin
        if (hold_junk) begin
          req_op = 3'($urandom_range(0, 7)); req_addr = 16'($urandom); req_wdata = 16'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
      check("ready_low_busy", req_ready, 0);
      check("strobes_exclusive", mem_read & mem_write, 0);
      if (!mem_write) check("wmask_zero_no_write", mem_wmask, 0);
      st = mem_read | mem_write;
      if (st && !prev_st) begin
        if (obs_nacc < 2) begin
          obs_addr[obs_nacc] = mem_address; obs_w[obs_nacc] = mem_write;
          obs_mask[obs_nacc] = mem_wmask; obs_wd[obs_nacc] = mem_wdata;
          if (obs_nacc == 1) obs_gap = low;
        end
        obs_nacc++;
      end
      if (st && obs_nacc >= 1 && obs_nacc <= 2) begin
        idx = obs_nacc - 1;
        obs_len[idx]++;
        if (obs_len[idx] == lat[idx]) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            t = mem_rd(mem_address);
            if (mem_wmask[0]) t[7:0] = mem_wdata[7:0];
            if (mem_wmask[1]) t[15:8] = mem_wdata[15:8];
            mem[mem_address] = t;
          end else begin
            mem_rdata = mem_rd(mem_address);
          end
        end
      end
      if (st) low = 0; else low++;
      prev_st = st;
      if (done || err) begin
        obs_done = done; obs_err = err; obs_rdata = rdata;
        fin = 1'b1; req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (!fin) check("txn_completed_in_budget", 0, 1);
    @(negedge clk);
    mem_resp = 1'b0;
    check("pulse_one_cycle", {30'd0, done, err}, 0);
    check("ready_after_finish", req_ready, 1);
    check("strobes_low_after", mem_read | mem_write, 0);
  endtask

  task automatic compare(input vec_t v);
    logic st_last;
    check("done", obs_done, v.exp_done);
    check("err", obs_err, !v.exp_done);
    check("rdata", obs_rdata, v.exp_rdata);
    check("access_count", obs_nacc, v.exp_nacc);
    check("addr0", obs_addr[0], v.exp_a0);
    check("write0", obs_w[0], is_st(v.op) && !is_ind(v.op));
    check("strobe_len0", obs_len[0], mn(v.lat0, MW));
    if (v.exp_nacc == 2 && obs_nacc == 2) begin
      check("addr1", obs_addr[1], v.exp_a1);
      check("write1", obs_w[1], is_st(v.op));
      check("strobe_len1", obs_len[1], mn(v.lat1, MW));
      check("gap_ge1", obs_gap >= 1, 1);
    end
    st_last = is_st(v.op) && (!is_ind(v.op) || (v.exp_nacc == 2 && obs_nacc == 2));
    if (st_last) begin
      check("wmask", obs_mask[obs_nacc - 1], v.exp_mask);
      check("wdata", obs_wd[obs_nacc - 1], v.exp_wd);
    end
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(LDB, 16'h3001, 16'h0000, 1, 16'h80AB, 0, 16'h0000, 4, 1, 1, 16'hFF80, 1, 16'h3000, 16'h0000, 2'b00, 16'h0000);
    tbl[1]  = mk(STB, 16'h4000, 16'h12C5, 0, 16'h0000, 0, 16'h0000, 2, 1, 1, 16'hFF80, 1, 16'h4000, 16'h0000, 2'b01, 16'hC5C5);
    tbl[2]  = mk(LDI, 16'h5003, 16'h0000, 1, 16'h6001, 1, 16'hBEEF, 1, 3, 1, 16'hBEEF, 2, 16'h5002, 16'h6000, 2'b00, 16'h0000);
    tbl[3]  = mk(STI, 16'h0010, 16'hA5A5, 1, 16'h7000, 0, 16'h0000, 2, 1, 1, 16'hBEEF, 2, 16'h0010, 16'h7000, 2'b11, 16'hA5A5);
    tbl[4]  = mk(LDW, 16'h2222, 16'h0000, 0, 16'h0000, 0, 16'h0000, 9, 1, 0, 16'hBEEF, 1, 16'h2222, 16'h0000, 2'b00, 16'h0000);
    tbl[5]  = mk(LDW, 16'h2223, 16'h0000, 1, 16'h1357, 0, 16'h0000, 4, 1, 1, 16'h1357, 1, 16'h2222, 16'h0000, 2'b00, 16'h0000);
    tbl[6]  = mk(STB, 16'h4001, 16'h00FE, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h1357, 1, 16'h4000, 16'h0000, 2'b10, 16'hFEFE);
    tbl[7]  = mk(LDB, 16'h4001, 16'h0000, 0, 16'h0000, 0, 16'h0000, 3, 1, 1, 16'hFFFE, 1, 16'h4000, 16'h0000, 2'b00, 16'h0000);
    tbl[8]  = mk(LDB, 16'h4000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'hFFC5, 1, 16'h4000, 16'h0000, 2'b00, 16'h0000);
    tbl[9]  = mk(LDI, 16'h0100, 16'h0000, 1, 16'hFFFF, 1, 16'h0042, 1, 1, 1, 16'h0042, 2, 16'h0100, 16'hFFFE, 2'b00, 16'h0000);
    tbl[10] = mk(LDB, 16'h5000, 16'h0000, 1, 16'h807F, 0, 16'h0000, 2, 1, 1, 16'h007F, 1, 16'h5000, 16'h0000, 2'b00, 16'h0000);
    tbl[11] = mk(LDI, 16'h5003, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 9, 0, 16'h007F, 2, 16'h5002, 16'h6000, 2'b00, 16'h0000);
    tbl[12] = mk(STW, 16'h1235, 16'h9ABC, 0, 16'h0000, 0, 16'h0000, 3, 1, 1, 16'h007F, 1, 16'h1234, 16'h0000, 2'b11, 16'h9ABC);
    tbl[13] = mk(STI, 16'h5003, 16'h1111, 0, 16'h0000, 0, 16'h0000, 1, 9, 0, 16'h007F, 2, 16'h5002, 16'h6000, 2'b11, 16'h1111);

    // Reset state.
    #12;
    cur_tag = "reset";
    check("ready", req_ready, 1);
    check("done", done, 0);
    check("err", err, 0);
    check("rdata", rdata, 16'h0000);
    check("strobes", {30'd0, mem_read, mem_write}, 0);
    check("wmask", mem_wmask, 0);
    check("mem_address", mem_address, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_txn(tbl[i], (i % 3) == 1);
      compare(tbl[i]);
    end
    model_rdata = tbl[13].exp_rdata;

    // Stray responses while idle must be ignored.
    cur_tag = "stray_resp";
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      check("ready", req_ready, 1);
      check("strobes", {30'd0, mem_read, mem_write}, 0);
      check("done_err", {30'd0, done, err}, 0);
      check("rdata", rdata, model_rdata);
    end
    mem_resp = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of an indirect pointer read.
    cur_tag = "reset_in_ptr";
    req_valid = 1'b1; req_op = LDI; req_addr = 16'h5003; req_wdata = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("ptr_read", mem_read, 1);
    check("ptr_addr", mem_address, 16'h5002);
    #2 reset_n = 1'b0;
    #1;
    check("read_dropped", mem_read, 0);
    check("ready", req_ready, 1);
    check("rdata_cleared", rdata, 16'h0000);
    model_rdata = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      build_rand(v);
      run_txn(v, $urandom_range(0, 3) == 0);
      compare(v);
      model_rdata = v.exp_rdata;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_sequencer.md
Name: lc3b_mem_sequencer

Overview:
- Sequences every data-memory access the LC-3b multicycle datapath issues for LDR, STR, LDB, STB, LDI and STI.
- Sits between the main control FSM and the single-ported memory interface.
- Handles byte-lane selection and write masking, and sign-extends loaded bytes.
- Runs the two-access pointer chase for indirect ops, and aborts stalled accesses with a watchdog.
- Control issues one request; the block drives the memory handshake and pulses done with load data.

Parameters:
- MAX_WAIT, 64: cycles a single memory access may wait for mem_resp before it is aborted. 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  control presents a request.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_op  in  3  lc3b_memop: mop_ldw, mop_ldb, mop_stw, mop_stb, mop_ldi, mop_sti.
- req_addr  in  16  effective address (lc3b_word).
- req_wdata  in  16  store data; STB uses bits [7:0].
- done  out  1  one-cycle pulse when the request completes successfully.
- err  out  1  one-cycle pulse when the watchdog aborts a request; mutually exclusive with done.
- rdata  out  16  load result; held until the next completed load.
- mem_address  out  16  memory address.
- mem_read  out  1  read strobe; held until mem_resp.
- mem_write  out  1  write strobe; held until mem_resp.
- mem_wmask  out  2  byte-lane write mask (lc3b_mem_wmask).
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid when mem_resp=1.
- mem_resp  in  1  access complete; single-cycle pulse.

Behaviour:
- Reset (async, reset_n=0): state IDLE, all outputs 0 except req_ready=1, wait counter 0. Reset mid-access drops the strobes immediately and the request is lost.
- All outputs are registered.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata.
  - For mop_ldi/mop_sti go to PTR; otherwise go to ACC.
  - Strobes appear the cycle after acceptance.
- State PTR:
  - mem_read=1, mem_address={addr[15:1],1'b0}.
  - On mem_resp, latch mem_rdata as the new access address and go to ACC.
  - The strobe drops in the same edge in which the state changes.
  - PTR and ACC are separated by at least one strobe-low cycle; ACC strobes rise one cycle later.
- State ACC, word ops (ldw/stw/ldi/sti):
  - mem_address = {addr[15:1],0}. Bit 0 of the address is ignored.
  - Stores drive mem_wmask=2'b11 and mem_wdata=wdata.
- State ACC, byte ops:
  - mem_address = {addr[15:1],0}.
  - mop_stb: mem_wdata={wdata[7:0],wdata[7:0]}; mem_wmask=2'b10 if addr[0] else 2'b01.
  - mop_ldb: result = sext16(addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]).
- ACC completion: on mem_resp, loads update rdata (stores leave it unchanged). Strobes and mask go to 0, done=1 for one cycle, and the state returns to IDLE.
- req_ready rises in the cycle following done.
- Read and write strobes are never both high. mem_wmask is 0 whenever mem_write=0.
- Watchdog:
  - The counter clears on entry to PTR and to ACC, and increments each cycle the strobe is high without mem_resp.
  - When the count reaches MAX_WAIT (with MAX_WAIT>0), drop the strobes, pulse err, leave rdata unchanged and return to IDLE.
  - mem_resp arriving in the same cycle as the limit wins: treat it as completion.
- mem_resp seen in IDLE is ignored.
- req_valid while not in IDLE is ignored; control must hold req_valid until it sees req_ready.
- Back-to-back: a new request may be accepted in the cycle after done.
- Address wrap: a pointer of 0xFFFF is used as 0xFFFE, with no special handling.

Decomposition:
- Add to lc3b_types:
  - lc3b_memop enum (3 bits).
  - lc3b_memseq_state enum {ms_idle, ms_ptr, ms_acc}.
- Use the existing lc3b_word, lc3b_byte and lc3b_mem_wmask types.
- One natural sub-module, lc3b_byte_lane: combinational lane select, sign-extend for LDB, and replicate plus wmask generation for STB. The FSM, watchdog counter and registers stay in the top.

Test Plan:
- LDB odd address:
  - Stimulus: req mop_ldb, addr 0x3001; memory returns 0x80AB after 3 cycles.
  - Required: mem_address=0x3000, mem_read high for exactly 4 cycles, then done with rdata=0xFF80.
- STB even address:
  - Stimulus: mop_stb, addr 0x4000, wdata 0x12C5.
  - Required: mem_wdata=0xC5C5, mem_wmask=2'b01, mem_write high until resp, then done; rdata unchanged.
- LDI chase:
  - Stimulus: mop_ldi, addr 0x5003; mem[0x5002]=0x6001, mem[0x6000]=0xBEEF.
  - Required: read 0x5002, at least one strobe-low cycle, read 0x6000, done, rdata=0xBEEF.
- STI chase:
  - Stimulus: mop_sti, addr 0x0010, wdata 0xA5A5; pointer word 0x7000.
  - Required: read 0x0010, then write 0x7000 with wmask 2'b11 and mem_wdata=0xA5A5.
- Watchdog:
  - Stimulus: MAX_WAIT=4, mop_ldw, mem_resp never asserted.
  - Required: strobe high 4 cycles, err pulse, no done, rdata unchanged, req_ready back to 1.
  - Variant: resp on the limit cycle gives done, not err.
- Reset and stray handshakes:
  - Stimulus: reset_n low during PTR of an LDI.
  - Required: mem_read=0 asynchronously, req_ready=1.
  - Also: a stray mem_resp in IDLE changes nothing, and req_valid while busy is not accepted.
